wb_spi_arbiter: RTL and testbench
=================================

WB_SPI_ARBITER -- requirements
Module: wb_spi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles without m_ack before forced termination (8-bit counter range).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: read data returned on timeout.
REQ-003 SHALL have ports, in order:
  clk  in  1  clock
  spi_reset  in  1  async active-low reset
  cpu_adr  in  32  CPU master address
  cpu_dat  in  32  CPU master write data
  cpu_sel  in  4  CPU byte selects
  cpu_we  in  1  CPU write enable
  cpu_cyc  in  1  CPU cycle request
  cpu_rdt  out  32  CPU read data
  cpu_ack  out  1  CPU acknowledge
  spi_adr  in  32  SPI-debug master address
  spi_dat  in  32  SPI-debug write data
  spi_sel  in  4  SPI-debug byte selects
  spi_we  in  1  SPI-debug write enable
  spi_cyc  in  1  SPI-debug cycle request
  spi_rdt  out  32  SPI-debug read data
  spi_ack  out  1  SPI-debug acknowledge
  m_adr / m_dat / m_sel / m_we / m_cyc  out  32/32/4/1/1  shared slave bus
  m_rdt  in  32  slave read data
  m_ack  in  1  slave acknowledge
  owner  out  2  00 idle, 01 CPU, 10 SPI
  timeout_err  out  1  sticky timeout flag
REQ-004 SHALL use clock clk and reset spi_reset, asynchronous, active-low.

Function
REQ-005 SHALL implement FSM IDLE, CPU, SPI; owner reflects state.
REQ-006 IDLE: only one cyc high -> grant it next cycle; both high -> grant the master not served last (round robin); none -> stay IDLE.
REQ-007 m_adr/m_dat/m_sel/m_we SHALL mux from owner; m_cyc = owner's cyc in CPU/SPI, 0 in IDLE; IDLE mux outputs zero.
REQ-008 m_ack SHALL route combinationally to owner's ack only; non-owner ack always 0; m_rdt drives both rdt outputs except during a timeout ack.
REQ-009 m_ack in CPU/SPI -> IDLE next cycle, last-served updated; one idle cycle between back-to-back grants.
REQ-010 Latency: cyc at cycle N in IDLE -> m_cyc at N+1; one-cycle slave -> ack at N+1.
REQ-011 Owner drops cyc before m_ack (abort) -> IDLE next cycle, no ack forwarded, last-served still updated.
REQ-012 Requests arriving outside IDLE SHALL wait; no preemption.

Reset
REQ-013 While spi_reset=0: state IDLE, owner=00, last-served=CPU (SPI wins first tie), counter=0, timeout_err=0, all acks 0, m_cyc 0; reset mid-transfer aborts without ack.

Configuration
REQ-014 Macro ARB_TIMEOUT_EN defined: counter increments each CPU/SPI cycle without m_ack, clears in IDLE; at TIMEOUT_CYCLES it drives one-cycle owner ack with rdt=ERR_DATA, m_cyc=0 that cycle, sets timeout_err (cleared only by reset), -> IDLE; m_ack on the same cycle takes precedence (normal ack, no error).
REQ-015 Macro undefined: no counter, timeout_err tied 0, grant held until m_ack or abort.

Verification
REQ-016 CPU read 0x100, slave acks 1 cycle later with 0x12345678 -> cpu_ack one cycle, cpu_rdt=0x12345678, spi_ack=0, owner 01 then 00.
REQ-017 Both cyc rise same cycle after reset -> SPI granted first (owner=10), then CPU after one IDLE cycle.
REQ-018 Both held continuously for 4 transfers -> grants alternate SPI, CPU, SPI, CPU.
REQ-019 SPI drops cyc mid-grant with no m_ack -> owner 00 next cycle, no spi_ack, CPU then granted.
REQ-020 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> after 8 grant cycles cpu_ack=1, cpu_rdt=0xDEADBEEF, timeout_err=1 until spi_reset.

Source files
------------

// File: rtl/wb_spi_arbiter.sv
// Two-master Wishbone arbiter: CPU and SPI-debug masters share one slave bus, round robin on ties.
// Optional ARB_TIMEOUT_EN adds a watchdog that force-terminates a stalled grant with ERR_DATA.
module wb_spi_arbiter #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        spi_reset,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_dat,
    input  logic [3:0]  cpu_sel,
    input  logic        cpu_we,
    input  logic        cpu_cyc,
    output logic [31:0] cpu_rdt,
    output logic        cpu_ack,
    input  logic [31:0] spi_adr,
    input  logic [31:0] spi_dat,
    input  logic [3:0]  spi_sel,
    input  logic        spi_we,
    input  logic        spi_cyc,
    output logic [31:0] spi_rdt,
    output logic        spi_ack,
    output logic [31:0] m_adr,
    output logic [31:0] m_dat,
    output logic [3:0]  m_sel,
    output logic        m_we,
    output logic        m_cyc,
    input  logic [31:0] m_rdt,
    input  logic        m_ack,
    output logic [1:0]  owner,
    output logic        timeout_err
);

    // Handshake: a master holds cyc high until it sees its ack for one cycle; dropping cyc
    // before ack abandons the transfer. The slave acks only while m_cyc is high.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CPU_ST = 2'b01,
        SPI_ST = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   last_spi, last_spi_nxt;  // 1 when SPI was the most recently served master
    logic   own_cyc;
    logic   own_ack;
    logic   tmo_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 8-bit counter (1..255)");
    end

    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset) begin
            state    <= IDLE;
            last_spi <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_spi <= last_spi_nxt;
        end
    end

    assign own_cyc = (state == CPU_ST) ? cpu_cyc :
                     (state == SPI_ST) ? spi_cyc : 1'b0;
    assign own_ack = own_cyc & m_ack;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset) begin
            tmo_cnt     <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE)
                tmo_cnt <= 8'd0;
            else if (!m_ack)
                tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_hit)
                timeout_err <= 1'b1;
        end
    end

    // A real slave ack on the limit cycle wins over the forced termination.
    assign tmo_hit = own_cyc && !m_ack && (tmo_cnt == 8'(TIMEOUT_CYCLES));
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        last_spi_nxt = last_spi;
        case (state)
            IDLE: begin
                if (cpu_cyc && spi_cyc)
                    state_nxt = last_spi ? CPU_ST : SPI_ST;
                else if (cpu_cyc)
                    state_nxt = CPU_ST;
                else if (spi_cyc)
                    state_nxt = SPI_ST;
            end
            CPU_ST: begin
                if (!cpu_cyc || m_ack || tmo_hit) begin
                    state_nxt    = IDLE;
                    last_spi_nxt = 1'b0;
                end
            end
            SPI_ST: begin
                if (!spi_cyc || m_ack || tmo_hit) begin
                    state_nxt    = IDLE;
                    last_spi_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_adr = 32'd0;
        m_dat = 32'd0;
        m_sel = 4'd0;
        m_we  = 1'b0;
        case (state)
            CPU_ST: begin
                m_adr = cpu_adr;
                m_dat = cpu_dat;
                m_sel = cpu_sel;
                m_we  = cpu_we;
            end
            SPI_ST: begin
                m_adr = spi_adr;
                m_dat = spi_dat;
                m_sel = spi_sel;
                m_we  = spi_we;
            end
            default: ;
        endcase
    end

    assign m_cyc   = own_cyc & ~tmo_hit;
    assign owner   = state;
    assign cpu_ack = (state == CPU_ST) & (own_ack | tmo_hit);
    assign spi_ack = (state == SPI_ST) & (own_ack | tmo_hit);
    assign cpu_rdt = ((state == CPU_ST) && tmo_hit) ? ERR_DATA : m_rdt;
    assign spi_rdt = ((state == SPI_ST) && tmo_hit) ? ERR_DATA : m_rdt;

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Directed bench for wb_spi_arbiter: per-cycle vector table plus reset and timeout sequences.
module tb_wb_spi_arbiter;

    localparam logic [31:0] CPU_ADR = 32'h0000_0100;
    localparam logic [31:0] CPU_DAT = 32'hC0DE_0001;
    localparam logic [31:0] SPI_ADR = 32'h0000_0200;
    localparam logic [31:0] SPI_DAT = 32'h5D0A_0002;

    logic        clk = 1'b0;
    logic        spi_reset;
    logic [31:0] cpu_adr, cpu_dat, spi_adr, spi_dat, m_rdt;
    logic [3:0]  cpu_sel, spi_sel;
    logic        cpu_we, cpu_cyc, spi_we, spi_cyc, m_ack;
    logic [31:0] cpu_rdt, spi_rdt, m_adr, m_dat;
    logic [3:0]  m_sel;
    logic        cpu_ack, spi_ack, m_we, m_cyc, timeout_err;
    logic [1:0]  owner;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       cpu_cyc;
        logic       spi_cyc;
        logic       ack;
        logic [1:0] owner;
        logic       mcyc;
        logic       cack;
        logic       sack;
    } vec_t;

    vec_t vq[$];

    wb_spi_arbiter #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .spi_reset(spi_reset),
        .cpu_adr(cpu_adr), .cpu_dat(cpu_dat), .cpu_sel(cpu_sel), .cpu_we(cpu_we),
        .cpu_cyc(cpu_cyc), .cpu_rdt(cpu_rdt), .cpu_ack(cpu_ack),
        .spi_adr(spi_adr), .spi_dat(spi_dat), .spi_sel(spi_sel), .spi_we(spi_we),
        .spi_cyc(spi_cyc), .spi_rdt(spi_rdt), .spi_ack(spi_ack),
        .m_adr(m_adr), .m_dat(m_dat), .m_sel(m_sel), .m_we(m_we), .m_cyc(m_cyc),
        .m_rdt(m_rdt), .m_ack(m_ack), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic s, input logic a, input logic [1:0] o,
                       input logic mc, input logic ca, input logic sa);
        vec_t v;
        v.cpu_cyc = c; v.spi_cyc = s; v.ack = a; v.owner = o;
        v.mcyc = mc; v.cack = ca; v.sack = sa;
        vq.push_back(v);
    endtask

    // Drive after the falling edge, sample 1 ns later, well clear of the rising edge.
    task automatic drive(input logic c, input logic s, input logic a, input logic [31:0] rd);
        @(negedge clk);
        cpu_cyc = c;
        spi_cyc = s;
        m_ack   = a;
        m_rdt   = rd;
        #1;
    endtask

    initial begin
        logic [31:0] exp_adr, exp_dat;
        logic [4:0]  exp_selwe;
        logic [31:0] rd;

        spi_reset = 1'b0;
        cpu_adr = CPU_ADR; cpu_dat = CPU_DAT; cpu_sel = 4'hF; cpu_we = 1'b0;
        spi_adr = SPI_ADR; spi_dat = SPI_DAT; spi_sel = 4'h3; spi_we = 1'b1;
        cpu_cyc = 1'b0; spi_cyc = 1'b0; m_ack = 1'b0; m_rdt = 32'd0;

        // Reset state, with requests and a stray ack present
        drive(1'b1, 1'b1, 1'b1, 32'hAAAA_5555);
        @(negedge clk); #1;
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_m_cyc", 32'(m_cyc), 32'd0);
        check("rst_acks", {30'd0, cpu_ack, spi_ack}, 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_m_adr", m_adr, 32'd0);
        @(negedge clk);
        cpu_cyc = 1'b0; spi_cyc = 1'b0; m_ack = 1'b0;
        spi_reset = 1'b1;

        //   cpu spi ack owner mcyc cack sack
        add(1, 0, 0, 2'b00, 0, 0, 0);  // CPU read request in IDLE
        add(1, 0, 1, 2'b01, 1, 1, 0);  // granted next cycle, slave acks at once
        add(0, 0, 0, 2'b00, 0, 0, 0);
        add(1, 1, 0, 2'b00, 0, 0, 0);  // tie after reset: SPI first
        add(1, 1, 1, 2'b10, 1, 0, 1);
        add(1, 1, 0, 2'b00, 0, 0, 0);  // mandatory idle cycle
        add(1, 1, 1, 2'b01, 1, 1, 0);
        add(1, 1, 0, 2'b00, 0, 0, 0);
        add(1, 1, 1, 2'b10, 1, 0, 1);
        add(1, 1, 0, 2'b00, 0, 0, 0);
        add(1, 1, 1, 2'b01, 1, 1, 0);
        add(1, 1, 0, 2'b00, 0, 0, 0);
        add(1, 1, 0, 2'b10, 1, 0, 0);  // SPI granted, slave stalls
        add(1, 0, 0, 2'b10, 0, 0, 0);  // SPI aborts
        add(1, 0, 0, 2'b00, 0, 0, 0);
        add(1, 0, 0, 2'b01, 1, 0, 0);  // CPU granted after abort
        add(1, 1, 1, 2'b01, 1, 1, 0);  // SPI request waits, no preemption
        add(0, 1, 0, 2'b00, 0, 0, 0);
        add(0, 1, 1, 2'b10, 1, 0, 1);
        add(0, 0, 0, 2'b00, 0, 0, 0);
        add(0, 0, 1, 2'b00, 0, 0, 0);  // stray ack in IDLE goes nowhere

        foreach (vq[i]) begin
            rd = 32'h1234_5678 + 32'(i);
            drive(vq[i].cpu_cyc, vq[i].spi_cyc, vq[i].ack, rd);
            case (vq[i].owner)
                2'b01:   begin exp_adr = CPU_ADR; exp_dat = CPU_DAT; exp_selwe = {4'hF, 1'b0}; end
                2'b10:   begin exp_adr = SPI_ADR; exp_dat = SPI_DAT; exp_selwe = {4'h3, 1'b1}; end
                default: begin exp_adr = 32'd0;   exp_dat = 32'd0;   exp_selwe = 5'd0;         end
            endcase
            check($sformatf("v%0d_owner", i), 32'(owner), 32'(vq[i].owner));
            check($sformatf("v%0d_m_cyc", i), 32'(m_cyc), 32'(vq[i].mcyc));
            check($sformatf("v%0d_cpu_ack", i), 32'(cpu_ack), 32'(vq[i].cack));
            check($sformatf("v%0d_spi_ack", i), 32'(spi_ack), 32'(vq[i].sack));
            check($sformatf("v%0d_m_adr", i), m_adr, exp_adr);
            check($sformatf("v%0d_m_dat", i), m_dat, exp_dat);
            check($sformatf("v%0d_m_selwe", i), {27'd0, m_sel, m_we}, {27'd0, exp_selwe});
            check($sformatf("v%0d_cpu_rdt", i), cpu_rdt, rd);
            check($sformatf("v%0d_spi_rdt", i), spi_rdt, rd);
        end

        // Reset in the middle of a CPU grant aborts without an ack
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        check("mid_grant_owner", 32'(owner), 32'd1);
        #1 spi_reset = 1'b0;
        m_ack = 1'b1;
        #1;
        check("mid_rst_owner", 32'(owner), 32'd0);
        check("mid_rst_m_cyc", 32'(m_cyc), 32'd0);
        check("mid_rst_cpu_ack", 32'(cpu_ack), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0055);
        spi_reset = 1'b1;

`ifdef ARB_TIMEOUT_EN
        // Slave never acks: forced termination after 8 grant cycles
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0055);
        check("tmo_idle_owner", 32'(owner), 32'd0);
        for (int g = 1; g <= 8; g++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0000_0055);
            check($sformatf("tmo_g%0d_owner", g), 32'(owner), 32'd1);
            check($sformatf("tmo_g%0d_ack", g), 32'(cpu_ack), 32'd0);
            check($sformatf("tmo_g%0d_m_cyc", g), 32'(m_cyc), 32'd1);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0055);
        check("tmo_cpu_ack", 32'(cpu_ack), 32'd1);
        check("tmo_cpu_rdt", cpu_rdt, 32'hDEADBEEF);
        check("tmo_spi_rdt", spi_rdt, 32'h0000_0055);
        check("tmo_m_cyc", 32'(m_cyc), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0055);
        check("tmo_after_owner", 32'(owner), 32'd0);
        check("tmo_after_ack", 32'(cpu_ack), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0000_0055);
            check($sformatf("tmo_sticky%0d", k), 32'(timeout_err), 32'd1);
        end
        #1 spi_reset = 1'b0;
        #1 check("tmo_cleared", 32'(timeout_err), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0055);
        spi_reset = 1'b1;
`else
        // Without the watchdog a stalled grant is held indefinitely
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0055);
        for (int g = 1; g <= 20; g++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0000_0055);
            check($sformatf("hold_g%0d_owner", g), 32'(owner), 32'd1);
            check($sformatf("hold_g%0d_ack", g), 32'(cpu_ack), 32'd0);
            check($sformatf("hold_g%0d_m_cyc", g), 32'(m_cyc), 32'd1);
        end
        check("hold_terr", 32'(timeout_err), 32'd0);
        check("hold_cpu_rdt", cpu_rdt, 32'h0000_0055);
        drive(1'b1, 1'b0, 1'b1, 32'h0BAD_F00D);
        check("hold_final_ack", 32'(cpu_ack), 32'd1);
        check("hold_final_rdt", cpu_rdt, 32'h0BAD_F00D);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("hold_release_owner", 32'(owner), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
